// File: rtl/cr_sa_dump_pkg.sv
// ---------------------------------------------------------------------------
// cr_cceip_64_saPKG
// Shared types and constants for the stats-aggregator dump engine.
//   SA_CNT_W      : width of one aggregator counter entry
//   SA_DUMP_W     : width of one dump word {parity, 7'd0, idx, count}
//   SA_IDX_W      : width of the counter index carried in each dump word
//   sa_dump_state_e : dump FSM states
//   saDumpPayload : builds the low 63 bits of a dump word
// ---------------------------------------------------------------------------
package cr_cceip_64_saPKG;

  localparam int SA_CNT_W  = 50;
  localparam int SA_DUMP_W = 64;
  localparam int SA_IDX_W  = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SNAP = 3'd1,
    WAIT = 3'd2,
    CLR  = 3'd3,
    XFER = 3'd4,
    DONE = 3'd5
  } sa_dump_state_e;

  // Everything below the parity bit; the parity bit is added by the caller
  // because whether it is computed depends on the build configuration.
  function automatic logic [SA_DUMP_W-2:0] saDumpPayload(
    input logic [SA_IDX_W-1:0] idx,
    input logic [SA_CNT_W-1:0] cnt
  );
    return {7'd0, idx, cnt};
  endfunction

endpackage

// File: rtl/cr_sa_dump_oreg.sv
// ---------------------------------------------------------------------------
// cr_sa_dump_oreg
// One-entry valid/ready holding register for the dump stream. A word loaded
// here stays frozen until the consumer accepts it, so the source data can
// change freely after the load.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : load i_data/i_last (honoured only when o_canLoad is high)
//   i_data      : word to load
//   i_last      : last-word flag to load with i_data
//   i_flush     : synchronous drop of the held word (abort)
//   i_ready     : consumer ready
//   o_canLoad   : register empty, or its word is being accepted this cycle
//   o_valid     : held word valid
//   o_data      : held word
//   o_last      : held word is the final one of the dump
// ---------------------------------------------------------------------------
module cr_sa_dump_oreg
  import cr_cceip_64_saPKG::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [SA_DUMP_W-1:0] i_data,
  input  logic                 i_last,
  input  logic                 i_flush,
  input  logic                 i_ready,
  output logic                 o_canLoad,
  output logic                 o_valid,
  output logic [SA_DUMP_W-1:0] o_data,
  output logic                 o_last
);

  logic                 r_valid;
  logic [SA_DUMP_W-1:0] r_data;
  logic                 r_last;

  // A new word may enter in the same cycle the current one leaves, which is
  // what gives one word per cycle when the consumer is always ready.
  assign o_canLoad = ~r_valid | i_ready;
  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_last    = r_last;

  // Flush has priority over a load so an aborted dump never emits another
  // word. The last flag is dropped together with valid so it never lingers
  // on an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load && o_canLoad) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/cr_sa_dump.sv
// ---------------------------------------------------------------------------
// cr_sa_dump
// Dump engine for the stats aggregator: requests a snapshot, optionally asks
// the aggregator to clear its live counters, then streams every snapshot
// entry out as a 64-bit word over a valid/ready interface.
// Build option: define CR_SA_DUMP_PARITY_EN to make dump_data[63] the even
// parity of dump_data[62:0]; otherwise bit 63 is constant 0.
// Parameters:
//   NUM_CNT   : counter entries walked per dump
//   SNAP_WAIT : cycles from sa_snap until the snapshot is considered stable
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   dump_start     : single-cycle dump request (ignored while busy)
//   dump_clear     : sampled with dump_start, clear live counters after snap
//   dump_abort     : synchronous abort of an active dump
//   sa_snapshot    : NUM_CNT x 50-bit snapshot array, entry i at [50*i +: 50]
//   sa_snap        : one-cycle snapshot request level
//   sa_clear_live  : one-cycle live-clear request level
//   dump_valid     : dump_data valid
//   dump_ready     : consumer ready
//   dump_data      : {parity, 7'd0, idx[5:0], count[49:0]}
//   dump_last      : word carries idx NUM_CNT-1
//   dump_busy      : engine not idle
//   dump_done      : one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module cr_sa_dump
  import cr_cceip_64_saPKG::*;
#(
  parameter int NUM_CNT   = 64,
  parameter int SNAP_WAIT = 4
)
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dump_start,
  input  logic                         dump_clear,
  input  logic                         dump_abort,
  input  logic [SA_CNT_W*NUM_CNT-1:0]  sa_snapshot,
  output logic                         sa_snap,
  output logic                         sa_clear_live,
  output logic                         dump_valid,
  input  logic                         dump_ready,
  output logic [SA_DUMP_W-1:0]         dump_data,
  output logic                         dump_last,
  output logic                         dump_busy,
  output logic                         dump_done
);

  localparam int WAIT_W = (SNAP_WAIT > 1) ? $clog2(SNAP_WAIT) : 1;
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(SNAP_WAIT - 1);
  localparam logic [SA_IDX_W-1:0] IDX_LAST  = SA_IDX_W'(NUM_CNT - 1);

  sa_dump_state_e        r_state;
  logic [WAIT_W-1:0]     r_waitCnt;
  logic                  r_clrQ;
  logic [SA_IDX_W-1:0]   r_idx;
  logic                  r_allLoaded;
  logic                  r_snap;
  logic                  r_clrLive;
  logic                  r_busy;
  logic                  r_done;

  logic [SA_CNT_W-1:0]   w_count;
  logic [SA_DUMP_W-2:0]  w_payload;
  logic                  w_parity;
  logic [SA_DUMP_W-1:0]  w_word;
  logic                  w_canLoad;
  logic                  w_load;
  logic                  w_flush;
  logic                  w_lastAccept;

  // Select the snapshot entry for the word about to be loaded. The snapshot
  // is only looked at here, so once a word sits in the output register a
  // later aggregator snap cannot tear it.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (r_idx == i[SA_IDX_W-1:0]) begin
        w_count = sa_snapshot[i*SA_CNT_W +: SA_CNT_W];
      end
    end
  end

  assign w_payload = saDumpPayload(r_idx, w_count);

`ifdef CR_SA_DUMP_PARITY_EN
  assign w_parity = ^w_payload;
`else
  assign w_parity = 1'b0;
`endif

  assign w_word = {w_parity, w_payload};

  // Loads stop once the final entry has been handed over and are suppressed
  // in the abort cycle so nothing new enters while the register is flushed.
  assign w_load       = (r_state == XFER) && !dump_abort && !r_allLoaded && w_canLoad;
  assign w_flush      = (r_state != IDLE) && dump_abort;
  assign w_lastAccept = dump_valid && dump_ready && dump_last;

  cr_sa_dump_oreg u_oreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_data    (w_word),
    .i_last    (r_idx == IDX_LAST),
    .i_flush   (w_flush),
    .i_ready   (dump_ready),
    .o_canLoad (w_canLoad),
    .o_valid   (dump_valid),
    .o_data    (dump_data),
    .o_last    (dump_last)
  );

  // Dump sequencer. The one-cycle request outputs default low every cycle
  // and are raised only on the transition into their state, which makes each
  // of them a single-cycle level aligned with that state and drops them
  // automatically on abort. Abort outranks everything except in IDLE, where
  // a coincident start wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_waitCnt   <= '0;
      r_clrQ      <= 1'b0;
      r_idx       <= '0;
      r_allLoaded <= 1'b0;
      r_snap      <= 1'b0;
      r_clrLive   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_snap    <= 1'b0;
      r_clrLive <= 1'b0;
      r_done    <= 1'b0;
      if (r_state == IDLE) begin
        if (dump_start) begin
          r_state <= SNAP;
          r_clrQ  <= dump_clear;
          r_snap  <= 1'b1;
          r_busy  <= 1'b1;
        end
      end else if (dump_abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          SNAP: begin
            r_state   <= WAIT;
            r_waitCnt <= '0;
          end
          WAIT: begin
            if (r_waitCnt == WAIT_LAST) begin
              r_idx       <= '0;
              r_allLoaded <= 1'b0;
              if (r_clrQ) begin
                r_state   <= CLR;
                r_clrLive <= 1'b1;
              end else begin
                r_state <= XFER;
              end
            end else begin
              r_waitCnt <= r_waitCnt + WAIT_W'(1);
            end
          end
          CLR: begin
            r_state     <= XFER;
            r_idx       <= '0;
            r_allLoaded <= 1'b0;
          end
          XFER: begin
            // idx holds at the final entry rather than wrapping
            if (w_load) begin
              if (r_idx == IDX_LAST) begin
                r_allLoaded <= 1'b1;
              end else begin
                r_idx <= r_idx + SA_IDX_W'(1);
              end
            end
            if (w_lastAccept) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sa_snap       = r_snap;
  assign sa_clear_live = r_clrLive;
  assign dump_busy     = r_busy;
  assign dump_done     = r_done;

endmodule

// File: doc/cr_sa_dump.md
CR_SA_DUMP -- requirements
Module: cr_sa_dump

Interface
REQ-001 Parameter NUM_CNT, default 64: number of aggregator counter entries walked per dump.
REQ-002 Parameter SNAP_WAIT, default 4: cycles from sa_snap assertion until sa_snapshot is read.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 dump_start  input  1  single-cycle request to begin a dump.
REQ-006 dump_clear  input  1  sampled with dump_start; 1 = clear live counters after the snapshot.
REQ-007 dump_abort  input  1  synchronous abort of an active dump.
REQ-008 sa_snapshot  input  50 x NUM_CNT  snapshot array from the stats aggregator.
REQ-009 sa_snap  output  1  snapshot request level to the aggregator, which edge-detects it.
REQ-010 sa_clear_live  output  1  live-clear request level to the aggregator, which edge-detects it.
REQ-011 dump_valid  output  1  dump_data valid.
REQ-012 dump_ready  input  1  consumer accepts when dump_valid & dump_ready.
REQ-013 dump_data  output  64  {parity, 7'd0, idx[5:0], count[49:0]}.
REQ-014 dump_last  output  1  qualifies the word with idx = NUM_CNT-1.
REQ-015 dump_busy  output  1  high in every state except IDLE.
REQ-016 dump_done  output  1  one-cycle pulse when the last word is accepted.

Function
REQ-017 FSM states are IDLE, SNAP, WAIT, CLR, XFER and DONE.
REQ-018 IDLE: dump_start moves to SNAP next cycle and latches dump_clear into clr_q.
REQ-019 SNAP: sa_snap is 1 for exactly one cycle, then the FSM goes to WAIT with the wait counter at 0.
REQ-020 WAIT: the counter increments each cycle; at count SNAP_WAIT-1 the FSM goes to CLR if clr_q, else to XFER.
REQ-021 CLR: sa_clear_live is 1 for exactly one cycle, then the FSM goes to XFER; the snapshot already captured is unaffected.
REQ-022 XFER: idx starts at 0; dump_data presents sa_snapshot[idx] registered, with dump_valid rising one cycle after entry.
REQ-023 dump_data, dump_last and dump_valid hold stable while dump_valid & ~dump_ready.
REQ-024 Each accepted word increments idx, and the next word is valid in the following cycle, giving one word per cycle at full throughput.
REQ-025 Acceptance of idx = NUM_CNT-1 enters DONE; DONE pulses dump_done for one cycle and returns to IDLE.
REQ-026 dump_start while dump_busy is ignored.
REQ-027 dump_start in the cycle dump_done pulses is also ignored.
REQ-028 dump_abort in any non-IDLE state returns to IDLE next cycle.
REQ-029 On abort, dump_valid, sa_snap and sa_clear_live drop and dump_done is not pulsed.
REQ-030 When dump_abort and dump_start coincide in IDLE, dump_start wins.
REQ-031 idx is 6 bits and never wraps within a dump; it resets to 0 on entry to XFER.
REQ-032 sa_snapshot is sampled only at the output-register load, so later aggregator snaps cannot tear a word once it is loaded.

Reset
REQ-033 Asserting rst_n low forces IDLE, clears idx, the wait counter and clr_q, and drives every output to 0, including dump_data.
REQ-034 Reset during XFER discards the in-flight word without pulsing dump_done.

Configuration
REQ-035 Macro CR_SA_DUMP_PARITY_EN: when defined, dump_data[63] is the XOR of dump_data[62:0] (even parity); when undefined, dump_data[63] is constant 0.

Structure
REQ-036 The state enum sa_dump_state_e and the localparams SA_CNT_W (50) and SA_DUMP_W (64) belong in cr_cceip_64_saPKG.
REQ-037 The one natural sub-module is cr_sa_dump_oreg, a one-entry valid/ready output holding register; the FSM and counters stay in cr_sa_dump.

Verification
REQ-038 Bench scenario: snapshot[i] = i*1000, dump_ready = 1, start with clear = 0 -> sa_snap pulses once; no sa_clear_live; 64 consecutive words; word 5 = 50'd5000 with idx 5; dump_last on idx 63; dump_done one cycle after the last acceptance.
REQ-039 Bench scenario: start with clear = 1 -> sa_clear_live pulses exactly SNAP_WAIT+1 cycles after sa_snap, then streaming starts.
REQ-040 Bench scenario: dump_ready toggles 1010... -> every word is held stable while stalled; all 64 idx values appear in order with no duplicates.
REQ-041 Bench scenario: dump_abort at idx 20 -> dump_valid is 0 next cycle; no dump_done; a new dump_start restarts from idx 0.
REQ-042 Bench scenario: rst_n low during WAIT and again during XFER -> all outputs are 0 immediately (asynchronous); the FSM is in IDLE after release.
REQ-043 Bench scenario: with CR_SA_DUMP_PARITY_EN, snapshot[0] = 50'h3 -> bit 63 = 0 and word idx 1 with count 50'h1 -> bit 63 = 0 (XOR 1^1); without the macro, bit 63 is always 0.
